// File: rtl/cp0_exc_unit_if.sv
// ---------------------------------------------------------------------------
// cp0_exc_unit_if
// Bundle between the M stage / next-PC logic and the CP0 exception unit.
//
// Pipeline -> CP0 (master drives, slave samples):
//   valid_m     M stage holds a real instruction (0 = bubble)
//   stall_m     M stage frozen; nothing commits this cycle
//   pc_m[31:0]  PC of the M-stage instruction
//   bd_m        M-stage instruction sits in a branch delay slot
//   exc_m       M-stage instruction raised a synchronous exception
//   exc_code_m  ExcCode that goes with exc_m
//   eret_m      M-stage instruction is eret
//   we          mtc0 commit
//   addr[4:0]   CP0 register number for mfc0/mtc0
//   wdata[31:0] mtc0 data
//   hwint[5:0]  level-sensitive hardware interrupt lines
// CP0 -> pipeline (slave drives, master samples):
//   rdata[31:0] mfc0 data, combinational from addr
//   kernel      exception/interrupt entry this cycle
//   eret        eret commits this cycle
//   epc[31:0]   current EPC register (eret redirect target)
//   flush       squash F/D/E (kernel | eret)
//   vector      handler entry address used when kernel is high
// ---------------------------------------------------------------------------
interface cp0_exc_unit_if;
  logic        valid_m;
  logic        stall_m;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [5:0]  hwint;

  logic [31:0] rdata;
  logic        kernel;
  logic        eret;
  logic [31:0] epc;
  logic        flush;
  logic [31:0] vector;

  modport master (
    output valid_m, stall_m, pc_m, bd_m, exc_m, exc_code_m, eret_m,
           we, addr, wdata, hwint,
    input  rdata, kernel, eret, epc, flush, vector
  );

  modport slave (
    input  valid_m, stall_m, pc_m, bd_m, exc_m, exc_code_m, eret_m,
           we, addr, wdata, hwint,
    output rdata, kernel, eret, epc, flush, vector
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// ---------------------------------------------------------------------------
// cp0_exc_unit
// Coprocessor-0 exception/interrupt controller sitting beside the M stage.
// Samples the committing instruction, decides exception/interrupt entry,
// holds SR(12) / Cause(13) / EPC(14) / PRId(15), serves mfc0/mtc0 and
// produces the kernel / eret / epc redirect signals for the next-PC logic.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cp0_exc_unit_if.slave (M-stage inputs, redirect/read outputs)
//
// Parameters:
//   EX_VECTOR  handler entry address, presented on bus.vector
//   PRID_VAL   read-only PRId contents
//
// Optional feature (compile-time macro CP0_COUNT_EN):
//   defined   -> Count(9) / Compare(11) timer; Count increments every
//                cycle, a Count==Compare match latches a timer pending bit
//                that is ORed into IP[15]; writing Compare clears it.
//   undefined -> regs 9/11 read as 0, writes ignored, IP[15] = hwint[5].
// ---------------------------------------------------------------------------
module cp0_exc_unit #(
  parameter logic [31:0] EX_VECTOR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL  = 32'h4D49_5053
) (
  input  logic          clk,
  input  logic          rst_n,
  cp0_exc_unit_if.slave bus
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  // Architectural state
  logic [5:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic        bd_reg;
  logic [5:0]  ip_reg;        // hwint sampled every cycle
  logic [4:0]  exc_code_reg;
  logic [31:0] epc_reg;

  // Control decode
  logic        timer_irq;
  logic [5:0]  ip_eff;        // IP as seen by software and by irq
  logic        irq;
  logic        take;
  logic        do_eret;
  logic        do_mtc0;
  logic [31:0] epc_entry;
  logic [31:0] rdata_c;

  // -------------------------------------------------------------------------
  // Optional Count/Compare timer
  // -------------------------------------------------------------------------
`ifdef CP0_COUNT_EN
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        timer_pend_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg      <= 32'd0;
      compare_reg    <= 32'd0;
      timer_pend_reg <= 1'b0;
    end else begin
      // Count free-runs (wrapping) regardless of stalls; mtc0 reloads it.
      if (do_mtc0 && bus.addr == REG_COUNT) begin
        count_reg <= bus.wdata;
      end else begin
        count_reg <= count_reg + 32'd1;
      end
      // A Compare write acknowledges the timer; it wins over a same-cycle match.
      if (do_mtc0 && bus.addr == REG_COMPARE) begin
        compare_reg    <= bus.wdata;
        timer_pend_reg <= 1'b0;
      end else if (count_reg == compare_reg) begin
        timer_pend_reg <= 1'b1;
      end
    end
  end

  assign timer_irq = timer_pend_reg;
`else
  assign timer_irq = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Effective IP: line 5 shares its bit with the timer when present.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_ip
      if (gi == 5) begin : g_ip_timer
        assign ip_eff[gi] = ip_reg[gi] | timer_irq;
      end else begin : g_ip_hw
        assign ip_eff[gi] = ip_reg[gi];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Commit decisions. Priority: interrupt > exception > eret > mtc0.
  // rst_n gates the redirect terms so kernel/eret/flush fall the moment
  // reset asserts, not at the next edge.
  // -------------------------------------------------------------------------
  assign irq     = (|(ip_eff & im_reg)) & ie_reg & ~exl_reg;
  assign take    = rst_n & ~bus.stall_m & bus.valid_m & ~exl_reg & (irq | bus.exc_m);
  assign do_eret = rst_n & ~bus.stall_m & bus.valid_m & bus.eret_m & ~take;
  assign do_mtc0 = bus.we & bus.valid_m & ~bus.stall_m & ~take & ~do_eret;

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign epc_entry = (bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m) & 32'hFFFF_FFFC;

  // -------------------------------------------------------------------------
  // SR / Cause / EPC state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_reg       <= 6'd0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= 6'd0;
      exc_code_reg <= 5'd0;
      epc_reg      <= 32'd0;
    end else begin
      // Interrupt lines are sampled even while M is stalled.
      ip_reg <= bus.hwint;

      if (take) begin
        exl_reg      <= 1'b1;
        bd_reg       <= bus.bd_m;
        exc_code_reg <= irq ? 5'd0 : bus.exc_code_m;
        epc_reg      <= epc_entry;
      end else if (do_eret) begin
        exl_reg <= 1'b0;
      end else if (do_mtc0) begin
        case (bus.addr)
          REG_SR: begin
            im_reg  <= bus.wdata[15:10];
            exl_reg <= bus.wdata[1];
            ie_reg  <= bus.wdata[0];
          end
          REG_EPC: begin
            epc_reg <= bus.wdata & 32'hFFFF_FFFC;
          end
          default: begin
            // Cause is read-only to software; PRId and unknown regs ignore writes.
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // mfc0 read mux: shows pre-edge state, so a write is visible next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    rdata_c = 32'd0;
    case (bus.addr)
      REG_SR:    rdata_c = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
      REG_CAUSE: rdata_c = {bd_reg, 15'd0, ip_eff, 3'd0, exc_code_reg, 2'd0};
      REG_EPC:   rdata_c = epc_reg;
      REG_PRID:  rdata_c = PRID_VAL;
`ifdef CP0_COUNT_EN
      REG_COUNT:   rdata_c = count_reg;
      REG_COMPARE: rdata_c = compare_reg;
`endif
      default:   rdata_c = 32'd0;
    endcase
  end

  assign bus.rdata  = rdata_c;
  assign bus.kernel = take;
  assign bus.eret   = do_eret;
  assign bus.flush  = take | do_eret;
  assign bus.epc    = epc_reg;
  assign bus.vector = EX_VECTOR;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_unit
// Directed stimulus with literal expectations, plus a field-level model of
// CP0 that predicts kernel/eret/flush/epc/rdata on every negative edge.
// ---------------------------------------------------------------------------
module tb_cp0_exc_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  cp0_exc_unit_if bus ();

  cp0_exc_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Field-level model of the CP0 registers
  // -------------------------------------------------------------------------
  logic [5:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic [31:0] m_count, m_cmp;
  logic        m_pend;

  task automatic model_reset();
    m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = '0;
    m_epc = '0; m_count = '0; m_cmp = '0; m_pend = 0;
  endtask

  function automatic logic [5:0] m_ipv();
    logic [5:0] v;
    v = m_ip;
`ifdef CP0_COUNT_EN
    if (m_pend) v = v | 6'b100000;
`endif
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return (32'(m_im) << 10) + (32'(m_exl) << 1) + 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) + (32'(m_ipv()) << 10) + (32'(m_code) << 2);
      5'd14: return m_epc;
      5'd15: return 32'h4D49_5053;
`ifdef CP0_COUNT_EN
      5'd9:  return m_count;
      5'd11: return m_cmp;
`endif
      default: return 32'd0;
    endcase
  endfunction

  logic        e_irq, e_take, e_eret, e_mt;
  logic [31:0] e_nc;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("m_kernel_rst", {31'd0, bus.kernel}, 32'd0);
      chk("m_eret_rst", {31'd0, bus.eret}, 32'd0);
      chk("m_flush_rst", {31'd0, bus.flush}, 32'd0);
      chk("m_epc_rst", bus.epc, 32'd0);
      chk("m_rdata_rst", bus.rdata, m_read(bus.addr));
    end else begin
      e_irq  = ((m_ipv() & m_im) != 6'd0) && m_ie && !m_exl;
      e_take = !bus.stall_m && bus.valid_m && !m_exl && (e_irq || bus.exc_m);
      e_eret = !bus.stall_m && bus.valid_m && bus.eret_m && !e_take;
      e_mt   = bus.we && bus.valid_m && !bus.stall_m && !e_take && !e_eret;

      chk("m_kernel", {31'd0, bus.kernel}, {31'd0, e_take});
      chk("m_eret", {31'd0, bus.eret}, {31'd0, e_eret});
      chk("m_flush", {31'd0, bus.flush}, {31'd0, e_take | e_eret});
      chk("m_epc", bus.epc, m_epc);
      chk("m_rdata", bus.rdata, m_read(bus.addr));

      // State advance for the coming rising edge (inputs are held until then).
      m_ip = bus.hwint;
`ifdef CP0_COUNT_EN
      e_nc = (e_mt && bus.addr == 5'd9) ? bus.wdata : m_count + 32'd1;
      if (e_mt && bus.addr == 5'd11) begin
        m_cmp  = bus.wdata;
        m_pend = 1'b0;
      end else if (m_count == m_cmp) begin
        m_pend = 1'b1;
      end
      m_count = e_nc;
`endif
      if (e_take) begin
        m_exl  = 1'b1;
        m_bd   = bus.bd_m;
        m_code = e_irq ? 5'd0 : bus.exc_code_m;
        m_epc  = (bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m) & 32'hFFFF_FFFC;
      end else if (e_eret) begin
        m_exl = 1'b0;
      end else if (e_mt) begin
        if (bus.addr == 5'd12) begin
          m_im  = bus.wdata[15:10];
          m_exl = bus.wdata[1];
          m_ie  = bus.wdata[0];
        end else if (bus.addr == 5'd14) begin
          m_epc = bus.wdata & 32'hFFFF_FFFC;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    bus.valid_m = 0; bus.stall_m = 0; bus.bd_m = 0; bus.exc_m = 0;
    bus.exc_code_m = '0; bus.eret_m = 0; bus.we = 0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    nop();
    bus.valid_m = 1; bus.we = 1; bus.addr = a; bus.wdata = d;
    $display("[TB] mtc0 r%0d <= %h", a, d);
    step();
    nop();
  endtask

  task automatic mfc0_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    nop();
    bus.addr = a;
    @(negedge clk);
    $display("[TB] mfc0 r%0d -> %h", a, bus.rdata);
    chk(nm, bus.rdata, exp);
    step();
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    nop();
    bus.pc_m  = 32'd0;
    bus.hwint = 6'd0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    chk("vector", bus.vector, 32'h0000_4180);
    mfc0_chk("prid", 5'd15, 32'h4D49_5053);
    mfc0_chk("sr_rst", 5'd12, 32'd0);
    mfc0_chk("cause_rst", 5'd13, 32'd0);
    mfc0_chk("epc_rst", 5'd14, 32'd0);

    // Interrupt entry: IM[10], IE set; hwint[0] visible one cycle later.
    mtc0(5'd12, 32'h0000_0401);
    mfc0_chk("sr_wr", 5'd12, 32'h0000_0401);
    nop(); bus.valid_m = 1; bus.pc_m = 32'h3000; bus.hwint = 6'b000001;
    @(negedge clk);
    chk("irq_latency", {31'd0, bus.kernel}, 32'd0);
    step();
    @(negedge clk);
    $display("[TB] irq pc=%h kernel=%b flush=%b", bus.pc_m, bus.kernel, bus.flush);
    chk("irq_take", {31'd0, bus.kernel}, 32'd1);
    chk("irq_flush", {31'd0, bus.flush}, 32'd1);
    step();
    mfc0_chk("irq_epc", 5'd14, 32'h0000_3000);
    mfc0_chk("irq_cause", 5'd13, 32'h0000_0400);
    mfc0_chk("irq_sr", 5'd12, 32'h0000_0403);

    // eret leaves the handler.
    bus.hwint = 6'd0;
    nop(); bus.valid_m = 1; bus.eret_m = 1;
    @(negedge clk);
    $display("[TB] eret eret=%b epc=%h", bus.eret, bus.epc);
    chk("eret1", {31'd0, bus.eret}, 32'd1);
    chk("eret1_epc", bus.epc, 32'h0000_3000);
    step();
    mfc0_chk("eret1_sr", 5'd12, 32'h0000_0401);

    // Synchronous exception in a delay slot.
    nop(); bus.valid_m = 1; bus.exc_m = 1; bus.exc_code_m = 5'd4; bus.bd_m = 1; bus.pc_m = 32'h3010;
    @(negedge clk);
    $display("[TB] exc code=4 bd=1 pc=%h kernel=%b", bus.pc_m, bus.kernel);
    chk("exc_take", {31'd0, bus.kernel}, 32'd1);
    step();
    mfc0_chk("exc_cause", 5'd13, 32'h8000_0010);
    chk("exc_epc", bus.epc, 32'h0000_300C);

    // Exception while EXL=1 is ignored.
    nop(); bus.valid_m = 1; bus.exc_m = 1; bus.exc_code_m = 5'd10; bus.pc_m = 32'h3020;
    @(negedge clk);
    $display("[TB] exc under EXL kernel=%b", bus.kernel);
    chk("exl_ignore", {31'd0, bus.kernel}, 32'd0);
    step();
    chk("exl_epc_kept", bus.epc, 32'h0000_300C);
    mfc0_chk("exl_cause_kept", 5'd13, 32'h8000_0010);

    nop(); bus.valid_m = 1; bus.eret_m = 1;
    @(negedge clk);
    $display("[TB] eret eret=%b epc=%h", bus.eret, bus.epc);
    chk("eret2", {31'd0, bus.eret}, 32'd1);
    chk("eret2_epc", bus.epc, 32'h0000_300C);
    step();
    mfc0_chk("eret2_sr", 5'd12, 32'h0000_0401);

    // Pending interrupt waits through bubbles and a stall.
    nop(); bus.hwint = 6'b000001;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      $display("[TB] bubble %0d kernel=%b", i, bus.kernel);
      chk("bubble_wait", {31'd0, bus.kernel}, 32'd0);
      step();
    end
    bus.valid_m = 1; bus.stall_m = 1; bus.pc_m = 32'h3040;
    @(negedge clk);
    $display("[TB] stall kernel=%b", bus.kernel);
    chk("stall_wait", {31'd0, bus.kernel}, 32'd0);
    step();
    bus.stall_m = 0;
    @(negedge clk);
    $display("[TB] released kernel=%b", bus.kernel);
    chk("pend_take", {31'd0, bus.kernel}, 32'd1);
    step();
    nop(); bus.hwint = 6'd0; bus.valid_m = 1; bus.eret_m = 1;
    step();
    nop();

    // Register write rules.
    mtc0(5'd14, 32'h1234_5677);
    mfc0_chk("epc_align", 5'd14, 32'h1234_5674);
    mtc0(5'd13, 32'hFFFF_FFFF);
    mfc0_chk("cause_ro", 5'd13, 32'h0000_0000);
    mtc0(5'd15, 32'd0);
    mfc0_chk("prid_ro", 5'd15, 32'h4D49_5053);

    // Same-cycle mtc0 is dropped by an exception, and by an eret.
    nop(); bus.valid_m = 1; bus.exc_m = 1; bus.exc_code_m = 5'd12; bus.pc_m = 32'h3100;
    bus.we = 1; bus.addr = 5'd14; bus.wdata = 32'hAAAA_0000;
    $display("[TB] exc code=12 with mtc0 r14");
    step();
    mfc0_chk("prio_epc", 5'd14, 32'h0000_3100);
    mfc0_chk("prio_cause", 5'd13, 32'h0000_0030);
    nop(); bus.valid_m = 1; bus.eret_m = 1; bus.we = 1; bus.addr = 5'd12; bus.wdata = 32'd0;
    $display("[TB] eret with mtc0 r12");
    step();
    mfc0_chk("prio_sr", 5'd12, 32'h0000_0401);

    // Stalled exception does not enter.
    nop(); bus.valid_m = 1; bus.stall_m = 1; bus.exc_m = 1; bus.exc_code_m = 5'd4;
    @(negedge clk);
    $display("[TB] stalled exc kernel=%b", bus.kernel);
    chk("stall_exc", {31'd0, bus.kernel}, 32'd0);
    step();
    nop();

`ifdef CP0_COUNT_EN
    mtc0(5'd12, 32'd0);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    for (int i = 0; i < 6; i++) begin
      nop(); bus.valid_m = 1; bus.pc_m = 32'h4000 + 32'(i * 4);
      @(negedge clk);
      $display("[TB] timer cycle %0d kernel=%b", i, bus.kernel);
      chk("timer_kernel", {31'd0, bus.kernel}, (i == 5) ? 32'd1 : 32'd0);
      step();
    end
    mfc0_chk("count_val", 5'd9, 32'd7);
    mtc0(5'd11, 32'd5);
    mfc0_chk("timer_clear", 5'd13, 32'h0000_0000);
    nop(); bus.valid_m = 1; bus.eret_m = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      nop(); bus.valid_m = 1;
      @(negedge clk);
      chk("timer_quiet", {31'd0, bus.kernel}, 32'd0);
      step();
    end
`else
    mtc0(5'd9, 32'd7);
    mfc0_chk("count_absent", 5'd9, 32'd0);
    mtc0(5'd11, 32'd7);
    mfc0_chk("compare_absent", 5'd11, 32'd0);
`endif

    // Reset asserted mid-handler.
    nop(); bus.valid_m = 1; bus.exc_m = 1; bus.exc_code_m = 5'd8; bus.pc_m = 32'h5000;
    @(negedge clk);
    chk("rst_pre_take", {31'd0, bus.kernel}, 32'd1);
    step();
    nop(); bus.valid_m = 1; bus.eret_m = 1;
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset eret=%b flush=%b", bus.eret, bus.flush);
    chk("rst_eret", {31'd0, bus.eret}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    bus.eret_m = 0; bus.exc_m = 1;
    #1;
    chk("rst_kernel", {31'd0, bus.kernel}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    $display("[TB] reset released kernel=%b", bus.kernel);
    chk("post_rst_take", {31'd0, bus.kernel}, 32'd1);
    step();
    mfc0_chk("post_rst_sr", 5'd12, 32'h0000_0002);
    mfc0_chk("post_rst_epc", 5'd14, 32'h0000_5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
